param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each stored word.
REQ-002 Parameter DEPTH, default 16: number of entries; power of two, >= 4.
REQ-003 Parameter AFULL_THRESH, default DEPTH-2: almost_full asserts at count >= this value.
REQ-004 Parameter AEMPTY_THRESH, default 2: almost_empty asserts at count <= this value.
REQ-005 Parameter FWFT, default 0: 0 selects registered-read mode, 1 selects first-word-fall-through mode.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 resetN  input  1  synchronous, active-low reset.
REQ-008 write_en  input  1  write request.
REQ-009 read_en  input  1  read request.
REQ-010 data_in  input  DATA_WIDTH  write data.
REQ-011 data_out  output  DATA_WIDTH  read data.
REQ-012 empty  output  1  count == 0.
REQ-013 full  output  1  count == DEPTH.
REQ-014 almost_empty  output  1  count <= AEMPTY_THRESH.
REQ-015 almost_full  output  1  count >= AFULL_THRESH.
REQ-016 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 overflow  output  1  one-cycle pulse flagging a rejected write.
REQ-018 underflow  output  1  one-cycle pulse flagging a rejected read.

Function
REQ-019 Write accepted iff write_en=1 and full=0 at the rising edge; data_in stored at write pointer, write pointer increments.
REQ-020 Read accepted iff read_en=1 and empty=0 at the rising edge; read pointer increments.
REQ-021 Pointers wrap DEPTH-1 -> 0; no other wrap behaviour.
REQ-022 Acceptance uses flags sampled in the same cycle; a read does not free space for a same-cycle write when full, and a write does not supply data for a same-cycle read when empty.
REQ-023 Accepted write and read in the same cycle: count unchanged, both pointers advance.
REQ-024 count: +1 on write-only, -1 on read-only, unchanged otherwise; registered.
REQ-025 empty, full, almost_empty, almost_full are decoded from the registered count; they update in the cycle after the causing edge.
REQ-026 FWFT=0: data_out registered; loaded with the head entry on the edge accepting a read (valid one cycle after read_en); holds value otherwise.
REQ-027 FWFT=1: data_out continuously presents the head entry while empty=0; an accepted read advances it to the next entry on the same edge; value undefined-but-stable (last head) while empty=1.
REQ-028 overflow asserts for exactly one cycle after an edge with write_en=1 and full=1; FIFO state unchanged by that write.
REQ-029 underflow asserts for exactly one cycle after an edge with read_en=1 and empty=1; data_out and state unchanged by that read.
REQ-030 Storage array has no reset; contents only observable through accepted reads.

Reset
REQ-031 On a rising edge with resetN=0: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0 (FWFT=0 register).
REQ-032 Requests during reset are ignored and produce no overflow/underflow pulse; reset mid-operation discards all stored entries.

Verification (DATA_WIDTH=8, DEPTH=4, AFULL_THRESH=3, AEMPTY_THRESH=1 unless stated)
REQ-033 Reset, then write 0x11,0x22,0x33,0x44 -> count 1..4, almost_full at count=3, full=1 after 4th write; 5th write 0x55 -> overflow pulse, count stays 4.
REQ-034 FWFT=0, from full, read 4 times -> data_out 0x11,0x22,0x33,0x44 each one cycle after read_en; empty=1 after 4th; 5th read -> underflow pulse, data_out stays 0x44.
REQ-035 Simultaneous write/read at count=2 for 10 cycles with incrementing data -> count stays 2, read data in write order across pointer wrap.
REQ-036 Simultaneous write/read when empty -> write accepted, read rejected with underflow pulse, count=1; when full -> read accepted, write rejected with overflow pulse, count=3.
REQ-037 FWFT=1, write 0xA5 into empty FIFO -> data_out=0xA5 the cycle empty deasserts, before any read_en; read -> empty=1 next cycle.
REQ-038 Fill to count=3, assert resetN=0 for one edge with write_en=1 -> count=0, empty=1, no overflow; subsequent write/read returns only the new data.

Source files
------------

// File: rtl/param_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : param_fifo
//  Description : Single-clock parameterised FIFO with registered or
//                first-word-fall-through read, threshold flags and
//                overflow/underflow pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     write_en,
    input  logic                     read_en,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int C_AW = $clog2(DEPTH);
    localparam int C_CW = C_AW + 1;
    localparam logic [C_AW-1:0] C_PTR_ONE = C_AW'(1);
    localparam logic [C_CW-1:0] C_CNT_ONE = C_CW'(1);
    localparam logic [C_CW-1:0] C_DEPTH   = C_CW'(DEPTH);
    localparam logic [C_CW-1:0] C_AFULL   = C_CW'(AFULL_THRESH);
    localparam logic [C_CW-1:0] C_AEMPTY  = C_CW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]       r_wr_ptr;
    logic [C_AW-1:0]       r_rd_ptr;
    logic [C_CW-1:0]       r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // Acceptance uses this cycle's flags, so a read never frees a slot for a
    // same-cycle write and a write never feeds a same-cycle read.
    assign w_wr_acc = write_en & ~full;
    assign w_rd_acc = read_en & ~empty;

    assign empty        = (r_count == '0);
    assign full         = (r_count == C_DEPTH);
    assign almost_empty = (r_count <= C_AEMPTY);
    assign almost_full  = (r_count >= C_AFULL);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    always_ff @(posedge clk) begin
        if (resetN && w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_overflow  <= write_en & full;
            r_underflow <= read_en & empty;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = r_mem[r_rd_ptr];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] r_data_out;
            always_ff @(posedge clk) begin
                if (!resetN) begin
                    r_data_out <= '0;
                end else if (w_rd_acc) begin
                    r_data_out <= r_mem[r_rd_ptr];
                end
            end
            assign data_out = r_data_out;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_param_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_fifo
//  Description : Directed + random bench for param_fifo in registered and
//                FWFT modes against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_fifo;

    localparam int DW = 8;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          resetN;
    logic          write_en;
    logic          read_en;
    logic [DW-1:0] data_in;

    logic [DW-1:0] dout0, dout1;
    logic          empty0, full0, aempty0, afull0, ov0, un0;
    logic          empty1, full1, aempty1, afull1, ov1, un1;
    logic [2:0]    cnt0, cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_dout0;
    logic          exp_ov;
    logic          exp_un;

    always #5 clk = ~clk;

    param_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(0)) dut0 (
        .clk(clk), .resetN(resetN), .write_en(write_en), .read_en(read_en), .data_in(data_in),
        .data_out(dout0), .empty(empty0), .full(full0), .almost_empty(aempty0),
        .almost_full(afull0), .count(cnt0), .overflow(ov0), .underflow(un0));

    param_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(1)) dut1 (
        .clk(clk), .resetN(resetN), .write_en(write_en), .read_en(read_en), .data_in(data_in),
        .data_out(dout1), .empty(empty1), .full(full1), .almost_empty(aempty1),
        .almost_full(afull1), .count(cnt1), .overflow(ov1), .underflow(un1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count0",  32'(cnt0),    32'(n));
        chk("count1",  32'(cnt1),    32'(n));
        chk("empty0",  32'(empty0),  32'(n == 0));
        chk("empty1",  32'(empty1),  32'(n == 0));
        chk("full0",   32'(full0),   32'(n == DP));
        chk("full1",   32'(full1),   32'(n == DP));
        chk("aempty0", 32'(aempty0), 32'(n <= 1));
        chk("aempty1", 32'(aempty1), 32'(n <= 1));
        chk("afull0",  32'(afull0),  32'(n >= 3));
        chk("afull1",  32'(afull1),  32'(n >= 3));
        chk("ovf0",    32'(ov0),     32'(exp_ov));
        chk("ovf1",    32'(ov1),     32'(exp_ov));
        chk("unf0",    32'(un0),     32'(exp_un));
        chk("unf1",    32'(un1),     32'(exp_un));
        chk("dout_reg", 32'(dout0),  32'(exp_dout0));
        if (n != 0) begin
            chk("dout_fwft", 32'(dout1), 32'(q[0]));
        end
    endtask

    // One clock: drive, apply the FIFO rules to the model, then compare.
    task automatic step(input logic rn, input logic we, input logic re, input logic [DW-1:0] d);
        bit was_full, was_empty;
        resetN   = rn;
        write_en = we;
        read_en  = re;
        data_in  = d;
        @(posedge clk);
        if (!rn) begin
            q.delete();
            exp_ov    = 1'b0;
            exp_un    = 1'b0;
            exp_dout0 = '0;
        end else begin
            was_full  = (q.size() == DP);
            was_empty = (q.size() == 0);
            exp_ov    = we && was_full;
            exp_un    = re && was_empty;
            if (re && !was_empty) begin
                exp_dout0 = q.pop_front();
            end
            if (we && !was_full) begin
                q.push_back(d);
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        logic [DW-1:0] v;
        resetN = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = '0;
        exp_ov = 1'b0; exp_un = 1'b0; exp_dout0 = '0;

        step(0, 0, 0, 8'h00);
        step(0, 1, 1, 8'hFF);

        // Fill, then an overflowing fifth write
        step(1, 1, 0, 8'h11);
        step(1, 1, 0, 8'h22);
        step(1, 1, 0, 8'h33);
        step(1, 1, 0, 8'h44);
        step(1, 1, 0, 8'h55);
        step(1, 0, 0, 8'h00);

        // Drain, then an underflowing fifth read
        for (int i = 0; i < 5; i++) step(1, 0, 1, 8'h00);
        step(1, 0, 0, 8'h00);

        // Steady-state simultaneous traffic at count 2 across pointer wrap
        step(1, 1, 0, 8'h60);
        step(1, 1, 0, 8'h61);
        for (int i = 0; i < 10; i++) step(1, 1, 1, 8'h62 + 8'(i));
        step(1, 0, 1, 8'h00);
        step(1, 0, 1, 8'h00);

        // Simultaneous requests at the empty and full boundaries
        step(1, 1, 1, 8'h70);
        step(1, 1, 0, 8'h71);
        step(1, 1, 0, 8'h72);
        step(1, 1, 0, 8'h73);
        step(1, 1, 1, 8'h74);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 8'h00);

        // Fall-through of a single word, then read it
        step(1, 1, 0, 8'hA5);
        step(1, 0, 1, 8'h00);

        // Reset in the middle of operation discards contents
        step(1, 1, 0, 8'h81);
        step(1, 1, 0, 8'h82);
        step(1, 1, 0, 8'h83);
        step(0, 1, 0, 8'h84);
        step(1, 1, 0, 8'h90);
        step(1, 0, 1, 8'h00);
        step(1, 0, 0, 8'h00);

        // Random traffic with rare resets
        for (int i = 0; i < 400; i++) begin
            v = 8'($urandom);
            step(($urandom_range(0, 49) != 0), 1'($urandom), 1'($urandom), v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
